memarb: RTL and testbench

Two-requester arbiter for one port of the dual-port data memory `mem`. Requester 0 is the pipeline load/store path (MA/MO stages) and has default priority. Requester 1 is the loader/DMA engine, protected by a starvation counter and allowed locked bursts. The arbiter drives the memory port, routes the 1-cycle-latency read data back to its owner, and produces a stall for the pipeline when requester 0 is refused.

---
 rtl/memarb.sv | 133 +++++++++++++
 tb/tb_memarb.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/memarb.sv
// rtl/memarb.sv - two-requester arbiter for one port of the data memory
`ifndef HBIT_ADDR
`define HBIT_ADDR 9
`endif
`ifndef HBIT_DATA
`define HBIT_DATA 15
`endif

// Requester 0 (pipeline load/store) wins by default. Requester 1 (loader/DMA)
// is protected by a starvation counter and may hold the port for locked bursts.
module memarb #(
   parameter int MAX_WAIT  = 4,
   parameter int MAX_BURST = 8
) (
   input  logic                 iw_clk,
   input  logic                 iw_rst,
   input  logic                 iw_req0,
   input  logic                 iw_we0,
   input  logic [`HBIT_ADDR:0]  iw_addr0,
   input  logic [`HBIT_DATA:0]  iw_wdata0,
   output logic                 ow_gnt0,
   output logic                 ow_rvalid0,
   output logic                 ow_stall0,
   input  logic                 iw_req1,
   input  logic                 iw_we1,
   input  logic                 iw_lock1,
   input  logic [`HBIT_ADDR:0]  iw_addr1,
   input  logic [`HBIT_DATA:0]  iw_wdata1,
   output logic                 ow_gnt1,
   output logic                 ow_rvalid1,
   output logic                 ow_mem_we,
   output logic [`HBIT_ADDR:0]  ow_mem_addr,
   output logic [`HBIT_DATA:0]  ow_mem_wdata,
   input  logic [`HBIT_DATA:0]  iw_mem_rdata,
   output logic [`HBIT_DATA:0]  ow_rdata
);

   typedef enum logic {S_IDLE, S_LOCK1} state_t;

   localparam logic [3:0] WAIT_LIM  = 4'(MAX_WAIT);
   localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

   state_t      state;
   logic [3:0]  r_wait;
   logic [3:0]  r_burst;
   logic        r_rd_pend;
   logic        r_rd_own;
   logic        starved;

   assign starved = iw_req1 && (r_wait >= WAIT_LIM);

   // Grant selection: a locked burst owns the port, otherwise starvation beats priority
   always_comb begin
      ow_gnt0 = 1'b0;
      ow_gnt1 = 1'b0;
      if (!iw_rst) begin
         if (state == S_LOCK1)
            ow_gnt1 = iw_req1;
         else if (starved)
            ow_gnt1 = 1'b1;
         else if (iw_req0)
            ow_gnt0 = 1'b1;
         else if (iw_req1)
            ow_gnt1 = 1'b1;
      end
   end

   // Memory port mux; with no grant the pipeline's address is parked on the port
   always_comb begin
      ow_mem_we    = 1'b0;
      ow_mem_addr  = iw_addr0;
      ow_mem_wdata = iw_wdata0;
      if (ow_gnt1) begin
         ow_mem_we    = iw_we1;
         ow_mem_addr  = iw_addr1;
         ow_mem_wdata = iw_wdata1;
      end else if (ow_gnt0) begin
         ow_mem_we    = iw_we0;
      end
   end

   assign ow_stall0  = iw_req0 & ~ow_gnt0;
   assign ow_rvalid0 = r_rd_pend & ~r_rd_own;
   assign ow_rvalid1 = r_rd_pend & r_rd_own;
   assign ow_rdata   = iw_mem_rdata;

   // Lock state, starvation/burst counters and read-response ownership
   always_ff @(posedge iw_clk or posedge iw_rst) begin
      if (iw_rst) begin
         state     <= S_IDLE;
         r_wait    <= 4'd0;
         r_burst   <= 4'd0;
         r_rd_pend <= 1'b0;
         r_rd_own  <= 1'b0;
      end else begin
         if (ow_gnt1)
            r_wait <= 4'd0;
         else if (iw_req1 && r_wait != 4'hF)
            r_wait <= r_wait + 4'd1;

         case (state)
            S_IDLE: begin
               if (ow_gnt1 && iw_lock1 && (MAX_BURST > 1)) begin
                  state   <= S_LOCK1;
                  r_burst <= 4'd1;
               end
            end
            S_LOCK1: begin
               // Dropping the request abandons the lock at once
               if (!iw_req1) begin
                  state <= S_IDLE;
               end else begin
                  r_burst <= r_burst + 4'd1;
                  if (!iw_lock1 || (r_burst + 4'd1) == BURST_LIM)
                     state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase

         if (ow_gnt1 && !iw_we1) begin
            r_rd_pend <= 1'b1;
            r_rd_own  <= 1'b1;
         end else if (ow_gnt0 && !iw_we0) begin
            r_rd_pend <= 1'b1;
            r_rd_own  <= 1'b0;
         end else begin
            r_rd_pend <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_memarb.sv
// tb/tb_memarb.sv - self-checking bench for memarb against a rule-level model
`ifndef HBIT_ADDR
`define HBIT_ADDR 9
`endif
`ifndef HBIT_DATA
`define HBIT_DATA 15
`endif

module tb_memarb;
   localparam int MAX_WAIT  = 4;
   localparam int MAX_BURST = 8;
   localparam int AW = `HBIT_ADDR + 1;
   localparam int DW = `HBIT_DATA + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0, we0, req1, we1, lock1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          gnt0, rvalid0, stall0, gnt1, rvalid1, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata, rdata;

   logic [DW-1:0] dev    [0:(1<<AW)-1];
   logic [DW-1:0] shadow [0:(1<<AW)-1];

   int checks = 0;
   int errors = 0;

   // reference model state
   bit            m_lock, m_pend, m_own;
   int            m_wait, m_beats;
   logic [DW-1:0] m_rdata;
   bit            e_g0, e_g1, e_we;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_wdata;

   // observations captured at the check point of the last tick
   logic          obs_g0, obs_g1, obs_we, obs_rv0, obs_rv1, obs_stall;
   logic [AW-1:0] obs_addr;
   logic [DW-1:0] obs_rdata;
   bit            rst_mid;

   memarb #(.MAX_WAIT(MAX_WAIT), .MAX_BURST(MAX_BURST)) dut (
      .iw_clk(clk), .iw_rst(rst),
      .iw_req0(req0), .iw_we0(we0), .iw_addr0(addr0), .iw_wdata0(wdata0),
      .ow_gnt0(gnt0), .ow_rvalid0(rvalid0), .ow_stall0(stall0),
      .iw_req1(req1), .iw_we1(we1), .iw_lock1(lock1),
      .iw_addr1(addr1), .iw_wdata1(wdata1),
      .ow_gnt1(gnt1), .ow_rvalid1(rvalid1),
      .ow_mem_we(mem_we), .ow_mem_addr(mem_addr), .ow_mem_wdata(mem_wdata),
      .iw_mem_rdata(mem_rdata), .ow_rdata(rdata)
   );

   always #5 clk = ~clk;

   // memory device: synchronous write, 1-cycle read latency
   initial begin
      for (int i = 0; i < (1 << AW); i++) dev[i] = DW'(i * 7) ^ 16'h5a5a;
      dev[16'h010] = 16'h1234;
      mem_rdata = '0;
      forever begin
         @(posedge clk);
         mem_rdata = dev[mem_addr];
         if (mem_we) dev[mem_addr] = mem_wdata;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_lock = 0; m_pend = 0; m_own = 0; m_wait = 0; m_beats = 0;
   endtask

   task automatic model_comb();
      e_g0 = 0; e_g1 = 0;
      if (!rst) begin
         if (m_lock)                          e_g1 = req1;
         else if (req1 && m_wait >= MAX_WAIT) e_g1 = 1;
         else if (req0)                       e_g0 = 1;
         else if (req1)                       e_g1 = 1;
      end
      if (e_g1)      begin e_we = we1; e_addr = addr1; e_wdata = wdata1; end
      else if (e_g0) begin e_we = we0; e_addr = addr0; e_wdata = wdata0; end
      else           begin e_we = 0;   e_addr = addr0; e_wdata = wdata0; end
   endtask

   task automatic model_seq();
      if (rst) begin
         model_reset();
      end else begin
         model_comb();
         if (e_g1 && !we1)      begin m_pend = 1; m_own = 1; m_rdata = shadow[addr1]; end
         else if (e_g0 && !we0) begin m_pend = 1; m_own = 0; m_rdata = shadow[addr0]; end
         else m_pend = 0;
         if (e_g1 && we1)      shadow[addr1] = wdata1;
         else if (e_g0 && we0) shadow[addr0] = wdata0;
         if (req1) m_wait = e_g1 ? 0 : (m_wait < 15 ? m_wait + 1 : 15);
         if (!m_lock) begin
            if (e_g1 && lock1 && MAX_BURST > 1) begin m_lock = 1; m_beats = 1; end
         end else if (!req1) begin
            m_lock = 0;
         end else begin
            m_beats++;
            if (!lock1 || m_beats == MAX_BURST) m_lock = 0;
         end
      end
   endtask

   // one clock cycle: inputs already driven at posedge+1, check at negedge
   task automatic tick();
      #4;
      if (rst) model_reset();
      model_comb();
      obs_g0 = gnt0; obs_g1 = gnt1; obs_we = mem_we; obs_addr = mem_addr;
      obs_rv0 = rvalid0; obs_rv1 = rvalid1; obs_rdata = rdata; obs_stall = stall0;
      chk("gnt0", gnt0, e_g0);
      chk("gnt1", gnt1, e_g1);
      chk("stall0", stall0, req0 & ~e_g0);
      chk("mem_we", mem_we, e_we);
      chk("mem_addr", mem_addr, e_addr);
      if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
      chk("rvalid0", rvalid0, m_pend & ~m_own);
      chk("rvalid1", rvalid1, m_pend & m_own);
      if (m_pend) chk("rdata", rdata, m_rdata);
      if (rst_mid) begin #2; rst = 1; end
      @(posedge clk);
      model_seq();
      #1;
   endtask

   initial begin
      int beats, first, last, n;
      for (int i = 0; i < (1 << AW); i++) shadow[i] = DW'(i * 7) ^ 16'h5a5a;
      shadow[16'h010] = 16'h1234;
      rst = 1; rst_mid = 0;
      req0 = 1; we0 = 0; addr0 = '0; wdata0 = '0;
      req1 = 1; we1 = 0; lock1 = 0; addr1 = '0; wdata1 = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_gnt0", gnt0, 0);
      chk("rst_gnt1", gnt1, 0);
      chk("rst_stall0", stall0, 1);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_rvalid", {rvalid0, rvalid1}, 0);
      rst = 0; req0 = 0; req1 = 0;

      // single requester 0 read
      req0 = 1; addr0 = 'h010;
      tick();
      chk("tp1_gnt0", obs_g0, 1);
      chk("tp1_addr", obs_addr, 'h010);
      chk("tp1_we", obs_we, 0);
      req0 = 0;
      tick();
      chk("tp1_rvalid0", obs_rv0, 1);
      chk("tp1_rvalid1", obs_rv1, 0);
      chk("tp1_rdata", obs_rdata, 16'h1234);

      // both held: starvation forces requester 1 every fifth cycle
      req0 = 1; addr0 = 'h011; req1 = 1; addr1 = 'h012;
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("tp2_gnt1", obs_g1, (k == 4 || k == 9));
         chk("tp2_gnt0", obs_g0, !(k == 4 || k == 9));
      end

      // locked write burst stops at MAX_BURST beats
      we1 = 1; lock1 = 1; addr1 = 'h100; wdata1 = 16'h7000;
      beats = 0; first = 0; last = 0; n = 0;
      while (beats < MAX_BURST && n < 40) begin
         tick();
         if (obs_g1) begin
            chk("tp3_addr", obs_addr, 'h100 + beats);
            if (beats == 0) first = n;
            last = n;
            beats++;
            addr1 = addr1 + 1; wdata1 = wdata1 + 1;
         end
         n++;
      end
      chk("tp3_beats", beats, MAX_BURST);
      chk("tp3_b2b", last - first, MAX_BURST - 1);
      tick();
      chk("tp3_after_gnt0", obs_g0, 1);

      // lock released on beat 3
      beats = 0; n = 0; addr1 = 'h180;
      while (beats < 3 && n < 40) begin
         lock1 = (beats == 2) ? 0 : 1;
         tick();
         if (obs_g1) begin beats++; addr1 = addr1 + 1; end
         n++;
      end
      chk("tp4_beats", beats, 3);
      tick();
      chk("tp4_gnt0", obs_g0, 1);
      chk("tp4_gnt1", obs_g1, 0);

      // requester 1 read cut off by a reset before the next edge
      req0 = 0; req1 = 1; we1 = 0; lock1 = 0; addr1 = 'h033;
      rst_mid = 1;
      tick();
      chk("tp5_gnt1", obs_g1, 1);
      rst_mid = 0;
      chk("tp5_rvalid1", rvalid1, 0);
      rst = 0;
      tick();
      chk("tp5_regrant", obs_g1, 1);
      chk("tp5_no_rvalid", obs_rv1, 0);
      // asynchronous clear of a pending response
      req1 = 0;
      #3; rst = 1; #1;
      chk("tp5_async_rvalid1", rvalid1, 0);
      @(posedge clk); model_seq(); #1;
      rst = 0;

      // forced write followed by a read of the same address
      req0 = 1; we0 = 0; addr0 = 'h005; req1 = 1; we1 = 1; addr1 = 'h020; wdata1 = 16'hABCD;
      n = 0;
      while (m_wait < MAX_WAIT && n < 20) begin tick(); n++; end
      tick();
      chk("tp6_forced", obs_g1, 1);
      chk("tp6_stall", obs_stall, 1);
      req1 = 0; addr0 = 'h020;
      tick();
      chk("tp6_rd_gnt", obs_g0, 1);
      req0 = 0;
      tick();
      chk("tp6_rvalid0", obs_rv0, 1);
      chk("tp6_rdata", obs_rdata, 16'hABCD);

      // randomized traffic with occasional resets
      for (int k = 0; k < 600; k++) begin
         req0 = ($urandom % 4) != 0; we0 = $urandom % 2;
         addr0 = AW'($urandom % 32); wdata0 = DW'($urandom);
         req1 = ($urandom % 3) != 0; we1 = $urandom % 2; lock1 = ($urandom % 4) != 0;
         addr1 = AW'($urandom % 32); wdata1 = DW'($urandom);
         rst = ($urandom % 60) == 0;
         tick();
      end
      rst = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
